sine_pwm_gen: RTL and testbench



---
 rtl/sinepwm_pkg.sv | 13 +
 rtl/sine_pwm_gen_pwm_core.sv | 31 +++
 rtl/sine_pwm_gen.sv | 59 +++++
 tb/tb_sine_pwm_gen.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/sinepwm_pkg.sv
// Shared defaults and helpers for the sinepwm sequencer / modulator.
package sinepwm_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned PWM_MAX    = (1 << DATA_W_DEF) - 1;

  // Width of a counter spanning 0..pps-1, never narrower than one bit.
  function automatic int unsigned per_w(input int unsigned pps);
    return (pps > 1) ? $clog2(pps) : 1;
  endfunction

endpackage

// File: rtl/sine_pwm_gen_pwm_core.sv
// Free-running PWM counter and comparator with a registered output.
// period_end flags the enabled edge on which the counter wraps MAX->0.
module pwm_core
  import sinepwm_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] duty,
  output logic              pwm_out,
  output logic              period_end
);

  logic [DATA_W-1:0] cnt;

  assign period_end = en & (cnt == '1);

  // Counter advances only while enabled; output compares pre-edge count and duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= en & (cnt < duty);
      if (en) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sine_pwm_gen.sv
// Sine ROM sequencer feeding a fixed-frequency PWM modulator.
// One ROM sample is held for PERIODS_PER_SAMPLE PWM periods.
module sine_pwm_gen
  import sinepwm_pkg::*;
#(
  parameter int unsigned ADDR_W             = ADDR_W_DEF,
  parameter int unsigned DATA_W             = DATA_W_DEF,
  parameter int unsigned PERIODS_PER_SAMPLE = 1
) (
  input  logic              clka,
  input  logic              rsta,
  input  logic              en,
  output logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] douta,
  output logic              pwm_out,
  output logic [DATA_W-1:0] duty_q,
  output logic              sample_strobe
);

  localparam int unsigned      PER_W    = per_w(PERIODS_PER_SAMPLE);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS_PER_SAMPLE - 1);

  logic [PER_W-1:0] per_cnt;
  logic             period_end;

  pwm_core #(
    .DATA_W(DATA_W)
  ) u_pwm_core (
    .clk       (clka),
    .rst       (rsta),
    .en        (en),
    .duty      (duty_q),
    .pwm_out   (pwm_out),
    .period_end(period_end)
  );

  // At each period end latch the ROM sample; every PERIODS_PER_SAMPLE periods step the address.
  always_ff @(posedge clka) begin
    if (rsta) begin
      addra         <= '0;
      per_cnt       <= '0;
      duty_q        <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= 1'b0;
      if (period_end) begin
        duty_q <= douta;
        if (per_cnt == PER_LAST) begin
          per_cnt       <= '0;
          addra         <= addra + 1'b1;
          sample_strobe <= 1'b1;
        end else begin
          per_cnt <= per_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sine_pwm_gen.sv
// Scoreboard bench for sine_pwm_gen: two instances (1 and 2 periods per sample)
// share stimulus; expected outputs come from an arithmetic model of elapsed
// enabled cycles since the last reset.
module tb_sine_pwm_gen;

  logic       clka = 1'b0;
  logic       rsta = 1'b1;
  logic       en   = 1'b0;

  logic [3:0] addra1, addra2;
  logic [7:0] douta1, douta2, duty1, duty2;
  logic       pwm1, pwm2, stb1, stb2;

  always #5 clka = ~clka;

  // Behavioural registered ROM: sample = 16 * address.
  always @(posedge clka) begin
    douta1 <= {addra1, 4'h0};
    douta2 <= {addra2, 4'h0};
  end

  sine_pwm_gen #(
    .ADDR_W(4), .DATA_W(8), .PERIODS_PER_SAMPLE(1)
  ) dut1 (
    .clka(clka), .rsta(rsta), .en(en), .addra(addra1), .douta(douta1),
    .pwm_out(pwm1), .duty_q(duty1), .sample_strobe(stb1)
  );

  sine_pwm_gen #(
    .ADDR_W(4), .DATA_W(8), .PERIODS_PER_SAMPLE(2)
  ) dut2 (
    .clka(clka), .rsta(rsta), .en(en), .addra(addra2), .douta(douta2),
    .pwm_out(pwm2), .duty_q(duty2), .sample_strobe(stb2)
  );

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] duty;
    logic       pwm;
    logic       stb;
  } exp_t;

  exp_t        q1[$];
  exp_t        q2[$];
  int unsigned n = 0;  // enabled edges since the last reset
  int          total = 0;
  int          bad = 0;

  // Duty in force after nn enabled cycles: the sample loaded at the most recent
  // period end, which read the address that was current during that period.
  function automatic int unsigned duty_for(input int unsigned nn, input int unsigned pps);
    if (nn < 256) return 0;
    return ((((nn / 256) - 1) / pps) % 16) * 16;
  endfunction

  function automatic exp_t predict(input int unsigned nn, input logic e, input logic r,
                                   input int unsigned pps);
    exp_t        x;
    int unsigned na;
    x = '0;
    if (r) return x;
    na     = e ? nn + 1 : nn;
    x.addr = 4'((na / 256 / pps) % 16);
    x.duty = 8'(duty_for(na, pps));
    x.pwm  = e && ((nn % 256) < duty_for(nn, pps));
    x.stb  = e && (na % 256 == 0) && ((na / 256) % pps == 0);
    return x;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, ex);
    end
  endtask

  // One clock: record expectations for the coming edge, then advance the model.
  task automatic step;
    q1.push_back(predict(n, en, rsta, 1));
    q2.push_back(predict(n, en, rsta, 2));
    @(posedge clka);
    if (rsta) n = 0;
    else if (en) n++;
    @(negedge clka);
  endtask

  // Monitor: every edge the DUTs present a full output set; compare against the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clka);
      #1;
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("addra_p1", addra1, e.addr);
        chk("duty_p1", duty1, e.duty);
        chk("pwm_p1", pwm1, e.pwm);
        chk("strobe_p1", stb1, e.stb);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        chk("addra_p2", addra2, e.addr);
        chk("duty_p2", duty2, e.duty);
        chk("pwm_p2", pwm2, e.pwm);
        chk("strobe_p2", stb2, e.stb);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    // Reset with en high, then long run covering full wraps of both instances.
    rsta = 1'b1;
    en   = 1'b1;
    repeat (3) step;
    rsta = 1'b0;
    repeat (33 * 256 + 10) step;

    // Enable drop at pwm_cnt = 100 for 50 cycles.
    for (int g = 0; g < 300 && (n % 256) != 100; g++) step;
    en = 1'b0;
    repeat (50) step;
    en = 1'b1;
    repeat (300) step;

    // Randomized enable pattern.
    repeat (3000) begin
      en = ($urandom_range(0, 7) != 0);
      step;
    end

    // Random mid-operation resets.
    repeat (4) begin
      repeat ($urandom_range(50, 700)) begin
        en = ($urandom_range(0, 5) != 0);
        step;
      end
      rsta = 1'b1;
      step;
      rsta = 1'b0;
    end

    // Reset at address 7, pwm_cnt 200, then confirm restart from address 0.
    en = 1'b1;
    for (int g = 0; g < 4500 && !(((n / 256) % 16) == 7 && (n % 256) == 200); g++) step;
    rsta = 1'b1;
    step;
    rsta = 1'b0;
    repeat (600) step;

    @(posedge clka);
    #2;
    chk("scoreboard_drained", q1.size() + q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
